// File: rtl/elastic_pipeline.sv
// Elastic pipeline: a chain of two-entry skid-buffer stages between a valid/ready
// source and sink. Every stage registers both its forward path (valid/data) and
// its backward path (ready), so long chains close timing without any
// combinational ready ripple. With zero stages the block degenerates to wires.

// One skid-buffer stage: a main register feeding the output and a skid register
// that catches the word arriving in the cycle the sink stalls.
module elastic_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  // EMPTY: nothing held; BUSY: main holds a word; FULL: main and skid both hold words.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;

  logic in_xfer;
  logic out_xfer;
  logic load_main_from_in;
  logic load_main_from_skid;
  logic load_skid;

  // ready_q is low whenever the stage is FULL, so in_xfer can never fire in FULL.
  assign in_xfer  = in_valid & ready_q;
  assign out_xfer = (state_q != ST_EMPTY) & out_ready;

  // Next-state and data-steering decode for the stage.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d             = state_q;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;

    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d           = ST_BUSY;
          load_main_from_in = 1'b1;
        end
      end

      ST_BUSY: begin
        if (in_xfer && out_xfer) begin
          // Word leaves and a new one replaces it in the same cycle.
          load_main_from_in = 1'b1;
        end else if (in_xfer) begin
          // Sink stalled: park the new word in the skid register.
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end

      ST_FULL: begin
        if (out_xfer) begin
          // Skid word becomes the head; input stays closed this cycle.
          state_d             = ST_BUSY;
          load_main_from_skid = 1'b1;
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State and registered ready; ready is computed from the next state so it is
  // valid in the same cycle the stage reaches that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block ordering.
      state_q <= state_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

  // Payload registers; their contents only matter while the matching state says valid.
  // NOTE: data registers carry no reset; validity lives entirely in state_q, which is reset.
  always_ff @(posedge clk) begin
    if (load_main_from_in) begin
      main_q <= in_data;
    end else if (load_main_from_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= in_data;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

endmodule

// Top level: PIPELINE_STAGES skid-buffer stages in series, or a straight
// wire-through when PIPELINE_STAGES is zero.
module elastic_pipeline #(
  parameter int DATA_WIDTH      = 8,
  parameter int PIPELINE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  generate
    if (PIPELINE_STAGES == 0) begin : g_wire
      // Pure combinational pass-through; clock and reset have nothing to drive.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign m_valid = s_valid;
      assign m_data  = s_data;
      assign s_ready = m_ready;
    end else begin : g_chain
      // Link k carries the handshake between stage k-1 and stage k; link 0 is
      // the source port and link PIPELINE_STAGES is the sink port.
      logic                  link_valid [0:PIPELINE_STAGES];
      logic [DATA_WIDTH-1:0] link_data  [0:PIPELINE_STAGES];
      logic                  link_ready [0:PIPELINE_STAGES];

      assign link_valid[0]               = s_valid;
      assign link_data[0]                = s_data;
      assign s_ready                     = link_ready[0];
      assign m_valid                     = link_valid[PIPELINE_STAGES];
      assign m_data                      = link_data[PIPELINE_STAGES];
      assign link_ready[PIPELINE_STAGES] = m_ready;

      for (genvar k = 0; k < PIPELINE_STAGES; k++) begin : g_stage
        elastic_stage #(
          .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
          .clk      (clk),
          .rst_n    (rst_n),
          .in_valid (link_valid[k]),
          .in_data  (link_data[k]),
          .in_ready (link_ready[k]),
          .out_valid(link_valid[k+1]),
          .out_data (link_data[k+1]),
          .out_ready(link_ready[k+1])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed bench for elastic_pipeline: two-stage streaming, back-pressure fill
// and drain, asynchronous mid-cycle reset, zero-stage wire mode, one-stage
// ready isolation, and a three-stage stall-heavy ordering run.
module tb_elastic_pipeline;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  // Two-stage instance (main device under test).
  logic         s_valid, s_ready, m_valid, m_ready;
  logic [W-1:0] s_data, m_data;
  // Zero-stage instance.
  logic         z_s_valid, z_s_ready, z_m_valid, z_m_ready;
  logic [W-1:0] z_s_data, z_m_data;
  // One-stage instance.
  logic         o_s_valid, o_s_ready, o_m_valid, o_m_ready;
  logic [W-1:0] o_s_data, o_m_data;
  // Three-stage instance.
  logic         r_s_valid, r_s_ready, r_m_valid, r_m_ready;
  logic [W-1:0] r_s_data, r_m_data;

  int checks = 0;
  int errors = 0;

  elastic_pipeline #(.DATA_WIDTH(W), .PIPELINE_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  elastic_pipeline #(.DATA_WIDTH(W), .PIPELINE_STAGES(0)) u_wire (
    .clk(clk), .rst_n(rst_n),
    .s_valid(z_s_valid), .s_data(z_s_data), .s_ready(z_s_ready),
    .m_valid(z_m_valid), .m_data(z_m_data), .m_ready(z_m_ready)
  );

  elastic_pipeline #(.DATA_WIDTH(W), .PIPELINE_STAGES(1)) u_one (
    .clk(clk), .rst_n(rst_n),
    .s_valid(o_s_valid), .s_data(o_s_data), .s_ready(o_s_ready),
    .m_valid(o_m_valid), .m_data(o_m_data), .m_ready(o_m_ready)
  );

  elastic_pipeline #(.DATA_WIDTH(W), .PIPELINE_STAGES(3)) u_three (
    .clk(clk), .rst_n(rst_n),
    .s_valid(r_s_valid), .s_data(r_s_data), .s_ready(r_s_ready),
    .m_valid(r_m_valid), .m_data(r_m_data), .m_ready(r_m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sent, rcv, first_acc, first_out, last_out, acc;
  logic         stall_prev;
  logic [W-1:0] held;
  localparam int RAND_WORDS = 300;

  initial begin
    rst_n     = 1'b1;
    s_valid   = 1'b0; s_data   = '0; m_ready   = 1'b0;
    z_s_valid = 1'b0; z_s_data = '0; z_m_ready = 1'b0;
    o_s_valid = 1'b0; o_s_data = '0; o_m_ready = 1'b0;
    r_s_valid = 1'b0; r_s_data = '0; r_m_ready = 1'b0;
    #2 rst_n = 1'b0;

    // ---------------- reset behaviour ----------------
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_s_ready_before_edge", s_ready, 0);
    tick();
    check("rel_s_ready_after_edge", s_ready, 1);
    check("rel_m_valid", m_valid, 0);

    // ---------------- streaming, m_ready high ----------------
    m_ready = 1'b1; sent = 0; rcv = 0; first_acc = -1; first_out = -1; last_out = -1;
    for (int c = 0; c < 40; c++) begin
      s_valid = (sent < 16);
      s_data  = W'(sent + 1);
      @(negedge clk);
      if (s_valid) check("stream_s_ready", s_ready, 1);
      if (m_valid) begin
        check("stream_m_data", m_data, rcv + 1);
        if (first_out < 0) first_out = c;
        last_out = c;
        rcv++;
      end
      if (s_valid && s_ready) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      tick();
    end
    s_valid = 1'b0;
    check("stream_count", rcv, 16);
    check("stream_latency", first_out - first_acc, 2);
    check("stream_back_to_back", last_out - first_out, 15);

    // ---------------- back-pressure fill ----------------
    m_ready = 1'b0; sent = 0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      s_valid = 1'b1;
      s_data  = W'(sent);
      @(negedge clk);
      if (m_valid) check("stall_m_data_stable", m_data, 0);
      if (s_valid && s_ready) begin
        sent++;
        acc++;
      end
      tick();
    end
    s_data = W'(sent);
    @(negedge clk);
    check("fill_accepted", acc, 4);
    check("fill_s_ready", s_ready, 0);
    check("fill_m_valid", m_valid, 1);
    check("fill_m_data", m_data, 0);
    tick();

    // ---------------- drain and resume ----------------
    rcv = 0; first_out = -1; last_out = -1;
    for (int c = 0; c < 40; c++) begin
      m_ready = 1'b1;
      s_valid = (sent < 16);
      s_data  = W'(sent);
      @(negedge clk);
      if (m_valid) begin
        check("drain_m_data", m_data, rcv);
        if (first_out < 0) first_out = c;
        last_out = c;
        rcv++;
      end
      if (s_valid && s_ready) sent++;
      tick();
    end
    s_valid = 1'b0;
    check("drain_count", rcv, 16);
    check("drain_first_cycle", first_out, 0);
    check("drain_no_gap", last_out - first_out, 15);

    // ---------------- asynchronous reset mid-operation ----------------
    m_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s_valid = 1'b1;
      s_data  = W'(8'h80 + c);
      tick();
    end
    @(negedge clk);
    check("full_s_ready", s_ready, 0);
    check("full_m_valid", m_valid, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", m_valid, 0);
    check("async_rst_s_ready", s_ready, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1;
    check("post_rst_s_ready_low", s_ready, 0);
    check("post_rst_m_valid", m_valid, 0);
    tick();
    check("post_rst_s_ready_high", s_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_no_stale", m_valid, 0);
      tick();
    end
    s_valid = 1'b1;
    s_data  = 8'h5A;
    @(negedge clk);
    check("fresh_accept_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    check("fresh_stage0_only", m_valid, 0);
    tick();
    @(negedge clk);
    check("fresh_m_valid", m_valid, 1);
    check("fresh_m_data", m_data, 8'h5A);
    tick();
    @(negedge clk);
    check("fresh_gone", m_valid, 0);
    tick();

    // ---------------- zero-stage wire mode ----------------
    z_s_valid = 1'b1; z_s_data = 8'hA5; z_m_ready = 1'b0;
    #1;
    check("wire_m_valid", z_m_valid, 1);
    check("wire_m_data", z_m_data, 8'hA5);
    check("wire_s_ready_low", z_s_ready, 0);
    z_m_ready = 1'b1;
    #1;
    check("wire_s_ready_high", z_s_ready, 1);
    z_s_valid = 1'b0; z_s_data = 8'h3C;
    #1;
    check("wire_m_valid_low", z_m_valid, 0);
    check("wire_m_data_follow", z_m_data, 8'h3C);
    tick();

    // ---------------- one-stage ready isolation ----------------
    o_m_ready = 1'b0; o_s_valid = 1'b1; o_s_data = 8'h11;
    @(negedge clk);
    check("one_ready_empty", o_s_ready, 1);
    tick();
    check("one_m_valid", o_m_valid, 1);
    check("one_m_data", o_m_data, 8'h11);
    o_s_data = 8'h22;
    tick();
    o_s_valid = 1'b0;
    check("one_full_ready", o_s_ready, 0);
    o_m_ready = 1'b1; #1;
    check("one_iso_rise", o_s_ready, 0);
    o_m_ready = 1'b0; #1;
    check("one_iso_fall", o_s_ready, 0);
    o_m_ready = 1'b1; #1;
    check("one_iso_rise2", o_s_ready, 0);
    check("one_hold_data", o_m_data, 8'h11);
    tick();
    check("one_ready_back", o_s_ready, 1);
    check("one_skid_to_main", o_m_data, 8'h22);
    o_m_ready = 1'b0; #1;
    check("one_busy_iso_fall", o_s_ready, 1);
    o_m_ready = 1'b1; #1;
    check("one_busy_iso_rise", o_s_ready, 1);
    tick();
    check("one_empty", o_m_valid, 0);
    o_m_ready = 1'b0;

    // ---------------- three-stage stall-heavy ordering ----------------
    sent = 0; rcv = 0; stall_prev = 1'b0; held = '0;
    for (int c = 0; c < 4000 && rcv < RAND_WORDS; c++) begin
      r_s_valid = (sent < RAND_WORDS) && ($urandom_range(0, 1) == 1);
      r_s_data  = W'(sent);
      r_m_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (stall_prev) begin
        check("rand_hold_valid", r_m_valid, 1);
        check("rand_hold_data", r_m_data, held);
      end
      if (r_m_valid && r_m_ready) begin
        check("rand_order", r_m_data, rcv % 256);
        rcv++;
      end
      stall_prev = r_m_valid && !r_m_ready;
      held       = r_m_data;
      if (r_s_valid && r_s_ready) sent++;
      tick();
    end
    r_s_valid = 1'b0;
    r_m_ready = 1'b0;
    check("rand_count", rcv, RAND_WORDS);
    @(negedge clk);
    check("rand_no_extra", r_m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elastic_pipeline.md
ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits, >= 1.
REQ-002 SHALL have parameter PIPELINE_STAGES, default 2: number of skid-buffer stages, >= 0.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_valid  input  1  upstream word valid.
REQ-006 SHALL have port s_data  input  DATA_WIDTH  upstream payload.
REQ-007 SHALL have port s_ready  output  1  block accepts word this cycle.
REQ-008 SHALL have port m_valid  output  1  downstream word valid.
REQ-009 SHALL have port m_data  output  DATA_WIDTH  downstream payload.
REQ-010 SHALL have port m_ready  input  1  downstream accepts word this cycle.

Function
REQ-011 Transfer occurs on a port when valid and ready are both high at a rising clk edge; all words SHALL emerge in order, none dropped or duplicated.
REQ-012 PIPELINE_STAGES == 0: pure wire, m_valid = s_valid, m_data = s_data, s_ready = m_ready; no registers.
REQ-013 PIPELINE_STAGES >= 1: chain of identical stages; stage k input is stage k-1 output; stage 0 faces s_*, last stage drives m_*.
REQ-014 Each stage holds main register (data + valid) and skid register (data + valid); capacity 2 words per stage, 2*PIPELINE_STAGES total.
REQ-015 Stage states: EMPTY (none valid), BUSY (main valid), FULL (main and skid valid); skid never valid with main empty.
REQ-016 Stage output valid = main valid; output data = main data.
REQ-017 Stage input ready SHALL be a register equal to (state != FULL); no combinational path from m_ready to s_ready or from s_valid to m_valid.
REQ-018 EMPTY + input transfer -> BUSY, word into main.
REQ-019 BUSY + input transfer + output transfer -> BUSY, new word into main.
REQ-020 BUSY + input transfer, no output transfer -> FULL, new word into skid.
REQ-021 BUSY + output transfer, no input transfer -> EMPTY.
REQ-022 FULL + output transfer -> BUSY, skid word moves to main (no input accepted, ready low).
REQ-023 No transfer on either side: state and data SHALL hold.
REQ-024 Latency with m_ready held high: word accepted at edge n SHALL appear on m_* (m_valid high) after edge n + PIPELINE_STAGES - 1, i.e. transferred out at edge n + PIPELINE_STAGES.
REQ-025 Throughput SHALL be one word per cycle whenever s_valid and m_ready stay high, including directly after a stall clears.
REQ-026 Data registers need not be reset; only valid bits and ready registers are reset.

Reset
REQ-027 rst_n low SHALL asynchronously force every stage EMPTY: m_valid = 0, all skid valid = 0.
REQ-028 During reset s_ready SHALL be 0; first edge after rst_n deasserts SHALL set s_ready = 1 (PIPELINE_STAGES >= 1).
REQ-029 Reset mid-operation SHALL discard all in-flight words; no stale word appears after reset release.

Verification
REQ-030 PIPELINE_STAGES=2, m_ready=1, s_valid=1 with s_data 0x01,0x02,...,0x10 on consecutive cycles -> m_data 0x01..0x10 on consecutive cycles, first output 2 edges after first accept, s_ready never low.
REQ-031 PIPELINE_STAGES=2, m_ready=0, s_valid=1 continuously with incrementing data -> exactly 4 words accepted, then s_ready=0; raise m_ready -> words 0..3 out in order, then stream resumes at one word/cycle with no gap beyond pipeline refill.
REQ-032 Random s_valid and m_ready (50 % each), 10000 words, DATA_WIDTH=8, PIPELINE_STAGES in {0,1,3} -> scoreboard order match, no loss/duplication; m_data/m_valid stable while m_valid=1 and m_ready=0.
REQ-033 Fill to FULL in all stages, assert rst_n=0 for 1 cycle asynchronously mid-cycle -> m_valid and s_ready drop immediately; after release, m_valid stays 0 until new input, s_ready=1 after first edge.
REQ-034 PIPELINE_STAGES=0 -> toggling m_ready reflects on s_ready same cycle; s_data 0xA5 with s_valid=1 appears on m_data same cycle.
REQ-035 Formal/assertion check: s_ready at cycle t depends only on registered state (no change within cycle when m_ready toggles), PIPELINE_STAGES=1.
